// File: rtl/arbitro_somador_pkg.sv
// Shared definitions for the Nrisc shared-adder arbiter: FSM encoding and
// default sizing of the requester array and the adder datapath.
package arbitro_somador_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    EXECUTA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int IDW_DEF   = 2;

endpackage

// File: rtl/arbitro_somador_rr_seletor.sv
// Rotated priority encoder: the first requester found at or after ponteiro
// (wrapping mod NREQ) wins. Purely combinational.
module rr_seletor #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ponteiro,
  output logic [IDW-1:0]  vencedor,
  output logic            algum
);

  // Scan from the farthest slot back toward ponteiro so the closest request wins.
  always_comb begin
    vencedor = '0;
    algum    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ponteiro) + k) % NREQ;
      if (req[idx]) vencedor = IDW'(idx);
    end
  end

endmodule

// File: rtl/arbitro_somador.sv
// Round-robin sequencer sharing one adder among NREQ requesters.
// Arbitrate -> grant + latch operands (EXECUTA) -> registered result (RESULTADO).
// Arbitration happens in OCIOSO and RESULTADO, giving one op every 2 cycles.
module arbitro_somador
  import arbitro_somador_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = IDW_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] opa,
  input  logic [NREQ*WIDTH-1:0] opb,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      saida,
  output logic                  carry,
  output logic                  valido,
  output logic [IDW-1:0]        id_saida
);

  estado_t          estado, estado_nx;
  logic [IDW-1:0]   ponteiro, ponteiro_nx;
  logic [IDW-1:0]   id_lat, id_lat_nx;
  logic [WIDTH-1:0] op_a, op_a_nx, op_b, op_b_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [WIDTH-1:0] saida_nx;
  logic             carry_nx, valido_nx;
  logic [IDW-1:0]   id_saida_nx;

  logic [IDW-1:0]   vencedor;
  logic             algum;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  // Unpack the flattened operand buses per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = opa[i*WIDTH +: WIDTH];
    assign b_arr[i] = opb[i*WIDTH +: WIDTH];
  end

  rr_seletor #(.NREQ(NREQ), .IDW(IDW)) u_sel (
    .req      (req),
    .ponteiro (ponteiro),
    .vencedor (vencedor),
    .algum    (algum)
  );

  // Next-state and next-output logic; everything defaults to hold, gnt/valido to 0.
  always_comb begin
    estado_nx   = estado;
    ponteiro_nx = ponteiro;
    id_lat_nx   = id_lat;
    op_a_nx     = op_a;
    op_b_nx     = op_b;
    gnt_nx      = '0;
    valido_nx   = 1'b0;
    saida_nx    = saida;
    carry_nx    = carry;
    id_saida_nx = id_saida;
    case (estado)
      OCIOSO, RESULTADO: begin
        if (algum) begin
          op_a_nx     = a_arr[vencedor];
          op_b_nx     = b_arr[vencedor];
          id_lat_nx   = vencedor;
          gnt_nx      = NREQ'(1) << vencedor;
          ponteiro_nx = (vencedor == IDW'(NREQ - 1)) ? '0 : vencedor + 1'b1;
          estado_nx   = EXECUTA;
        end else begin
          estado_nx = OCIOSO;
        end
      end
      EXECUTA: begin
        // The adder proper: kept as one inline expression so it can be swapped out.
        {carry_nx, saida_nx} = {1'b0, op_a} + {1'b0, op_b};
        id_saida_nx = id_lat;
        valido_nx   = 1'b1;
        estado_nx   = RESULTADO;
      end
      default: estado_nx = OCIOSO;
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      ponteiro <= '0;
      id_lat   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      gnt      <= '0;
      valido   <= 1'b0;
      saida    <= '0;
      carry    <= 1'b0;
      id_saida <= '0;
    end else begin
      estado   <= estado_nx;
      ponteiro <= ponteiro_nx;
      id_lat   <= id_lat_nx;
      op_a     <= op_a_nx;
      op_b     <= op_b_nx;
      gnt      <= gnt_nx;
      valido   <= valido_nx;
      saida    <= saida_nx;
      carry    <= carry_nx;
      id_saida <= id_saida_nx;
    end
  end

endmodule

// File: tb/tb_arbitro_somador.sv
// Directed bench for arbitro_somador: reset, single ops, overflow, hold,
// round-robin order, mid-operation reset, and random traffic with a
// no-starvation watch. Inputs driven and outputs sampled on the falling edge.
module tb_arbitro_somador;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] opa, opb;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      saida;
  logic                  carry;
  logic                  valido;
  logic [IDW-1:0]        id_saida;

  int n_chk = 0;
  int n_err = 0;
  logic prev_v = 1'b0;

  arbitro_somador #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .opa      (opa),
    .opb      (opb),
    .gnt      (gnt),
    .saida    (saida),
    .carry    (carry),
    .valido   (valido),
    .id_saida (id_saida)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    opa[i*WIDTH +: WIDTH] = a;
    opb[i*WIDTH +: WIDTH] = b;
  endtask

  // Protocol invariants, checked every cycle.
  always @(negedge clock) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_and_valido", 32'((gnt != '0) && valido), 32'd0);
    chk("valido_twice", 32'(prev_v && valido), 32'd0);
    prev_v = valido;
  end

  logic [7:0] ra [4];
  logic [7:0] rb [4];
  logic [8:0] rsum [4];
  int         espera [4];

  initial begin
    ra = '{8'd7, 8'd57, 8'd107, 8'd157};
    rb = '{8'd100, 8'd160, 8'd220, 8'd24};
    rsum = '{9'd107, 9'd217, 9'd327, 9'd181};

    reset_n = 1'b0;
    req     = 4'b1111;
    opa     = '0;
    opb     = '0;

    // Reset held 3 cycles with every requester asking.
    repeat (3) @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_id", 32'(id_saida), 32'd0);

    // First grant after release goes to requester 0.
    set_ops(0, 8'd10, 8'd20);
    reset_n = 1'b1;
    @(negedge clock);
    chk("first_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    @(negedge clock);
    chk("first_valido", 32'(valido), 32'd1);
    chk("first_saida", 32'(saida), 32'd30);
    chk("first_id", 32'(id_saida), 32'd0);

    // Single op on requester 2, arbitrated from RESULTADO.
    set_ops(2, 8'd2, 8'd3);
    req = 4'b0100;
    @(negedge clock);
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_v0", 32'(valido), 32'd0);
    req = 4'b0000;
    @(negedge clock);
    chk("single_gnt_off", 32'(gnt), 32'd0);
    chk("single_valido", 32'(valido), 32'd1);
    chk("single_saida", 32'(saida), 32'd5);
    chk("single_carry", 32'(carry), 32'd0);
    chk("single_id", 32'(id_saida), 32'd2);

    // Overflow on requester 1: 200+100 = 300 -> 44 with carry.
    set_ops(1, 8'd200, 8'd100);
    req = 4'b0010;
    @(negedge clock);
    chk("ovf_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    @(negedge clock);
    chk("ovf_valido", 32'(valido), 32'd1);
    chk("ovf_saida", 32'(saida), 32'd44);
    chk("ovf_carry", 32'(carry), 32'd1);
    chk("ovf_id", 32'(id_saida), 32'd1);

    // Idle: outputs hold, no valido, no grant.
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("hold_valido", 32'(valido), 32'd0);
      chk("hold_gnt", 32'(gnt), 32'd0);
      chk("hold_saida", 32'(saida), 32'd44);
      chk("hold_carry", 32'(carry), 32'd1);
      chk("hold_id", 32'(id_saida), 32'd1);
    end

    // Round-robin under full continuous load, starting from ponteiro=0.
    reset_n = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) set_ops(i, ra[i], rb[i]);
    reset_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      chk("rr_v0", 32'(valido), 32'd0);
      @(negedge clock);
      chk("rr_gnt_off", 32'(gnt), 32'd0);
      chk("rr_valido", 32'(valido), 32'd1);
      chk("rr_id", 32'(id_saida), 32'(k % 4));
      chk("rr_sum", 32'({carry, saida}), 32'(rsum[k % 4]));
    end

    // Mid-operation reset during EXECUTA for requester 3 (ponteiro is 1 now).
    req = 4'b1000;
    @(negedge clock);
    chk("mid_gnt", 32'(gnt), 32'b1000);
    reset_n = 1'b0;
    req = 4'b0000;
    @(negedge clock);
    chk("mid_valido", 32'(valido), 32'd0);
    chk("mid_gnt_clr", 32'(gnt), 32'd0);
    chk("mid_saida", 32'(saida), 32'd0);
    chk("mid_carry", 32'(carry), 32'd0);
    chk("mid_id", 32'(id_saida), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_no_valido", 32'(valido), 32'd0);
    // ponteiro back at 0: requester 0 beats 3.
    req = 4'b1001;
    @(negedge clock);
    chk("mid_ptr0_gnt", 32'(gnt), 32'b0001);
    req = 4'b1000;
    @(negedge clock);
    chk("mid_v_id0", 32'(id_saida), 32'd0);
    @(negedge clock);
    chk("mid_r3_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    @(negedge clock);
    chk("mid_r3_valido", 32'(valido), 32'd1);
    chk("mid_r3_id", 32'(id_saida), 32'd3);
    chk("mid_r3_sum", 32'({carry, saida}), 32'd181);

    // Random traffic; requesters drop req in their grant cycle.
    for (int i = 0; i < 4; i++) espera[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (valido)
        chk("rnd_sum", 32'({carry, saida}), 32'(rsum[id_saida]));
      if (gnt != '0) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            chk("rnd_gnt_req", 32'(req[i]), 32'd1);
            chk("rnd_starve", 32'(espera[i] <= NREQ - 1), 32'd1);
            espera[i] = 0;
          end else if (req[i]) begin
            espera[i]++;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && ($urandom_range(2) == 0)) req[i] = 1'b1;
      end
    end
    req = 4'b0000;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
